// File: rtl/button_debounce_sync.sv
// Push-button front end: 2-flop synchroniser, strict consecutive-sample debounce FSM,
// registered level plus press/release pulses. Optional long-press detection: BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             sync_1, sync_2;
    logic             pressed_nxt, press_pulse_nxt, release_pulse_nxt;

    // Elaboration guard: the debounce counter needs at least two samples.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_param_check
        $error("button_debounce_sync: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    // Two-flop synchroniser; only sync_2 is consumed downstream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= button_raw;
            sync_2 <= sync_1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RELEASED;
            count         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_pulse_nxt;
            release_pulse <= release_pulse_nxt;
        end
    end

    // Next-state logic; any sample disagreeing with the pending level restarts qualification.
    always_comb begin
        state_nxt         = state;
        count_nxt         = count;
        press_pulse_nxt   = 1'b0;
        release_pulse_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (sync_2) begin
                    state_nxt = PRESS_PEND;
                    count_nxt = CNT_W'(1);
                end else begin
                    count_nxt = '0;
                end
            end
            PRESS_PEND: begin
                if (!sync_2) begin
                    state_nxt = RELEASED;
                    count_nxt = '0;
                end else if (count == CNT_LAST) begin
                    state_nxt       = PRESSED;
                    count_nxt       = '0;
                    press_pulse_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_2) begin
                    state_nxt = RELEASE_PEND;
                    count_nxt = CNT_W'(1);
                end else begin
                    count_nxt = '0;
                end
            end
            RELEASE_PEND: begin
                if (sync_2) begin
                    state_nxt = PRESSED;
                    count_nxt = '0;
                end else if (count == CNT_LAST) begin
                    state_nxt         = RELEASED;
                    count_nxt         = '0;
                    release_pulse_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                count_nxt = '0;
            end
        endcase
        pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_PEND);
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    // Counts cycles spent pressed; cleared on the same edge that drops pressed.
    always_comb begin
        hold_nxt = hold_cnt;
        if (!pressed_nxt) begin
            hold_nxt = '0;
        end else if (pressed && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            hold_cnt   <= hold_nxt;
            long_press <= (hold_nxt == HOLD_MAX);
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_sync.sv
// Directed bench for button_debounce_sync (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, 10 ns clock).
module tb_button_debounce_sync;

    logic clk = 1'b0;
    logic reset_n;
    logic button_raw;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int n_cmp = 0;
    int n_err = 0;
    int n_pp  = 0;
    int n_rp  = 0;
    logic lp_exp;

    always #5 clk = ~clk;

    button_debounce_sync #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw   (button_raw),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic pp, input logic rp);
        chk({tag, ".pressed"}, pressed, p);
        chk({tag, ".press_pulse"}, press_pulse, pp);
        chk({tag, ".release_pulse"}, release_pulse, rp);
    endtask

    initial begin
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        lp_exp = 1'b1;
`else
        lp_exp = 1'b0;
`endif
        // 1: reset with raw high, then press qualifies 6 edges after reset release
        reset_n    = 1'b0;
        button_raw = 1'b1;
        tick(3);
        chk_out("t1_reset", 1'b0, 1'b0, 1'b0);
        chk("t1_reset.long_press", long_press, 1'b0);
        reset_n = 1'b1;
        tick(5);
        chk_out("t1_edge5", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("t1_edge6", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("t1_after", 1'b1, 1'b0, 1'b0);

        button_raw = 1'b0;
        tick(5);
        chk_out("t1_rel_edge5", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_out("t1_rel_edge6", 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("t1_rel_after", 1'b0, 1'b0, 1'b0);

        // 2: bounce 1,0,1,0 each 2 cycles then settle high
        for (int k = 0; k < 4; k++) begin
            button_raw = (k % 2 == 0);
            repeat (2) begin
                tick(1);
                chk_out("t2_bounce", 1'b0, 1'b0, 1'b0);
            end
        end
        button_raw = 1'b1;
        tick(5);
        chk_out("t2_edge5", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("t2_edge6", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("t2_after", 1'b1, 1'b0, 1'b0);

        // 3: 3-cycle low glitch while pressed is rejected
        button_raw = 1'b0;
        tick(3);
        button_raw = 1'b1;
        repeat (6) begin
            tick(1);
            chk_out("t3_glitch", 1'b1, 1'b0, 1'b0);
        end
        button_raw = 1'b0;
        tick(5);
        chk_out("t3_rel_edge5", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_out("t3_rel_edge6", 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("t3_rel_after", 1'b0, 1'b0, 1'b0);

        // 3b: a 4-cycle high pulse is just long enough to be accepted
        button_raw = 1'b1;
        tick(4);
        button_raw = 1'b0;
        tick(1);
        chk_out("t3b_edge5", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("t3b_edge6", 1'b1, 1'b1, 1'b0);
        tick(3);
        chk_out("t3b_hold", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_out("t3b_release", 1'b0, 1'b0, 1'b1);
        tick(2);

        // 4: reset while PRESS_PEND (count=2) discards progress
        button_raw = 1'b1;
        tick(4);
        chk_out("t4_pend", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick(1);
        chk_out("t4_pend_reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(5);
        chk_out("t4_requal_edge5", 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("t4_requal_edge6", 1'b1, 1'b1, 1'b0);
        tick(2);
        chk_out("t4_pressed", 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick(1);
        chk_out("t4_pressed_reset", 1'b0, 1'b0, 1'b0);
        button_raw = 1'b0;
        tick(1);
        reset_n = 1'b1;
        repeat (8) begin
            tick(1);
            chk_out("t4_quiet", 1'b0, 1'b0, 1'b0);
        end

        // 5: long press after 20 pressed cycles, cleared on the release edge
        button_raw = 1'b1;
        tick(6);
        chk_out("t5_press", 1'b1, 1'b1, 1'b0);
        chk("t5_press.long_press", long_press, 1'b0);
        tick(19);
        chk("t5_cycle19.long_press", long_press, 1'b0);
        tick(1);
        chk("t5_cycle20.long_press", long_press, lp_exp);
        tick(5);
        chk("t5_held.long_press", long_press, lp_exp);
        button_raw = 1'b0;
        tick(5);
        chk("t5_rel_edge5.long_press", long_press, lp_exp);
        chk_out("t5_rel_edge5", 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("t5_rel_edge6.long_press", long_press, 1'b0);
        chk_out("t5_rel_edge6", 1'b0, 1'b0, 1'b1);
        tick(2);

        // 6: five bouncy presses give exactly five press and five release pulses
        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 28; s++) begin
                if (s < 3)        button_raw = (s != 1);
                else if (s < 13)  button_raw = 1'b1;
                else if (s < 15)  button_raw = (s == 14);
                else              button_raw = 1'b0;
                tick(1);
                if (press_pulse)   n_pp++;
                if (release_pulse) n_rp++;
                chk("t6_exclusive", press_pulse & release_pulse, 1'b0);
            end
        end
        n_cmp++;
        assert (n_pp == 5)
        else begin
            n_err++;
            $error("FAIL t6_press_count: observed %0d expected 5", n_pp);
        end
        n_cmp++;
        assert (n_rp == 5)
        else begin
            n_err++;
            $error("FAIL t6_release_count: observed %0d expected 5", n_rp);
        end
        chk_out("t6_end", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
